seq_detect_ctrl: RTL and testbench
==================================

Name: seq_detect_ctrl

Overview:
Programmable serial pattern-detection controller. It accepts a pattern and mode configuration through a ready/valid handshake, then arms and runs a detection window over a serial bitstream. It emits match pulses, a saturating match count and a window-done pulse. It generalises the hard-wired 1101 detector into a configurable, sequenced block for the day-level FSM library.

Parameters:
PAT_W, 4, pattern length in bits (≥2); bits compared MSB = oldest.
CNT_W, 8, width of match counter.
WIN_W, 8, width of window-length field.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
cfg_valid  in  1  configuration offer
cfg_ready  out  1  controller can accept configuration
cfg_pattern  in  PAT_W  pattern to detect
cfg_overlap  in  1  1 = overlapping matches allowed
cfg_win  in  WIN_W  bits to examine; 0 = unbounded
start  in  1  begin detection window
stop  in  1  abort window
in_valid  in  1  in_bit is valid this cycle
in_bit  in  1  serial data
busy  out  1  high in RUN
match  out  1  one-cycle pulse per detected pattern
match_count  out  CNT_W  matches in current/last window
done  out  1  one-cycle pulse on window completion

Behaviour:
- Reset (rst=0, async): state IDLE; cfg_ready=1; busy=0; match=0; done=0; match_count=0; pattern/overlap/window regs=0; shift reg and fill count=0.
- States: IDLE, ARMED, RUN, DONE.
- IDLE: cfg_ready=1. A cfg_valid&cfg_ready edge captures pattern/overlap/win → ARMED. start is ignored.
- ARMED: cfg_ready=1, so re-configuration overwrites the regs and the state stays ARMED. start → RUN: clear match_count, shift reg, fill count and bit count. If start and cfg_valid are both high, the configuration is captured and start is honoured with the new config.
- RUN: cfg_ready=0; busy=1. On each in_valid=1 edge:
  - shift in_bit into LSB;
  - fill=min(fill+1,PAT_W);
  - bitcnt++.
  - The accepted bit hits when the post-shift fill==PAT_W and shift==pattern.
  - A hit sets match=1 on the next cycle (latency 1 from the accepting edge) and increments match_count, saturating at 2^CNT_W-1.
- Non-overlap mode: a hit resets fill to 0, so the next match needs PAT_W fresh bits.
- in_valid=0 cycles leave all state unchanged. in_valid is ignored outside RUN.
- Window end: when cfg_win≠0 and the accepted bit makes bitcnt==cfg_win → DONE. A hit on that bit still pulses match; match and done are asserted in the same cycle.
- DONE: done=1 for one cycle, busy=0 → IDLE. match_count holds until the next start.
- stop in RUN (priority over in_valid that cycle; that bit is discarded) → IDLE with no done pulse; match_count retained. stop in other states is ignored.
- cfg_win=0: RUN persists until stop; bitcnt wraps harmlessly.
- Async reset mid-RUN returns all outputs to reset values immediately.

Optional Feature:
SEQ_DET_FIRST_IDX_EN:
- Defined: adds outputs first_idx [WIN_W] and first_vld [1]. On the first hit of a window, first_idx = bitcnt value of the hitting bit (0-based), and first_vld=1 registered with match. Both are cleared on start and on reset.
- Undefined: ports and logic are absent.

Decomposition:
- Package seq_det_pkg: state enum (IDLE/ARMED/RUN/DONE), default width localparams.
- Sub-module seq_shift_match: shift register, fill counter and compare. Inputs: shift enable, clear, non-overlap clear. Output: combinational hit.
- seq_detect_ctrl holds the FSM, counters and handshake.

Test Plan:
- Overlap: PAT_W=4, pattern 1101, overlap=1, win=0; stream 1101101 → match after bits 3 and 6; match_count=2.
- Non-overlap: same stream, overlap=0 → match after bit 3 only; match_count=1.
- Window: win=8; 8 valid bits with in_valid gaps → done one cycle after the 8th bit; busy falls; state IDLE; gap cycles do not count.
- Last-bit match: win=4, stream 1101 → match and done asserted in the same cycle; count=1.
- Saturation: CNT_W=2, pattern 1111, overlap=1; 8 ones → 5 match pulses; match_count saturates at 3.
- Abort/reset: stop after 5 bits → IDLE, no done, count held. rst low mid-RUN → all outputs at reset values, cfg_ready=1.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared types and default widths for the programmable serial pattern detector.
package seq_det_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int PAT_W_DEF = 4;
  localparam int CNT_W_DEF = 8;
  localparam int WIN_W_DEF = 8;

endpackage

// File: rtl/seq_detect_ctrl_if.sv
// Configuration handshake bundle: the master offers a pattern/mode/window, the slave accepts it.
interface seq_detect_ctrl_if
  import seq_det_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int WIN_W = WIN_W_DEF
) ();

  logic             cfg_valid;
  logic             cfg_ready;
  logic [PAT_W-1:0] cfg_pattern;
  logic             cfg_overlap;
  logic [WIN_W-1:0] cfg_win;

  modport master (
    output cfg_valid, cfg_pattern, cfg_overlap, cfg_win,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_pattern, cfg_overlap, cfg_win,
    output cfg_ready
  );

endinterface

// File: rtl/seq_shift_match.sv
// Serial shift register with fill counter; hit is combinational on the bit being accepted.
module seq_shift_match
  import seq_det_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en,
  input  logic             clr,
  input  logic             nov_clr,
  input  logic             bit_in,
  input  logic [PAT_W-1:0] pattern,
  output logic             hit
);

  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

  logic [PAT_W-1:0]  shift_reg;
  logic [PAT_W-1:0]  shift_next;
  logic [FILL_W-1:0] fill_reg;
  logic [FILL_W-1:0] fill_post;

  // New bit enters at the LSB so the MSB always holds the oldest bit.
  assign shift_next[0] = bit_in;
  for (genvar gi = 1; gi < PAT_W; gi++) begin : g_shift
    assign shift_next[gi] = shift_reg[gi-1];
  end

  always_comb begin
    fill_post = (fill_reg == FILL_FULL) ? fill_reg : fill_reg + FILL_W'(1);
    hit       = shift_en && (fill_post == FILL_FULL) && (shift_next == pattern);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_reg <= '0;
      fill_reg  <= '0;
    end else if (clr) begin
      shift_reg <= '0;
      fill_reg  <= '0;
    end else if (shift_en) begin
      shift_reg <= shift_next;
      fill_reg  <= (hit && nov_clr) ? '0 : fill_post;
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Sequenced pattern-detection controller: configure, arm, run a bounded or open window.
// Optional SEQ_DET_FIRST_IDX_EN adds first_idx/first_vld reporting the first hit position.
module seq_detect_ctrl
  import seq_det_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int WIN_W = WIN_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  seq_detect_ctrl_if.slave cfg,
  input  logic             start,
  input  logic             stop,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic             busy,
  output logic             match,
  output logic [CNT_W-1:0] match_count,
  output logic             done
`ifdef SEQ_DET_FIRST_IDX_EN
  ,
  output logic [WIN_W-1:0] first_idx,
  output logic             first_vld
`endif
);

  state_t           state_reg;
  state_t           state_next;
  logic [PAT_W-1:0] pattern_reg;
  logic             overlap_reg;
  logic [WIN_W-1:0] win_reg;
  logic [WIN_W-1:0] bitcnt_reg;
  logic [WIN_W-1:0] bitcnt_post;
  logic [CNT_W-1:0] count_reg;
  logic             match_reg;
  logic             cfg_fire;
  logic             start_fire;
  logic             accept;
  logic             win_end;
  logic             hit;

  assign cfg_fire    = cfg.cfg_valid && cfg.cfg_ready;
  assign start_fire  = (state_reg == ARMED) && start;
  // stop wins over in_valid, so the bit presented alongside stop is dropped.
  assign accept      = (state_reg == RUN) && in_valid && !stop;
  assign bitcnt_post = bitcnt_reg + WIN_W'(1);
  assign win_end     = accept && (win_reg != '0) && (bitcnt_post == win_reg);

  seq_shift_match #(
    .PAT_W (PAT_W)
  ) u_shift_match (
    .clk      (clk),
    .rst      (rst),
    .shift_en (accept),
    .clr      (start_fire),
    .nov_clr  (!overlap_reg),
    .bit_in   (in_bit),
    .pattern  (pattern_reg),
    .hit      (hit)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (cfg_fire) state_next = ARMED;
      ARMED:   if (start) state_next = RUN;
      RUN: begin
        if (stop)         state_next = IDLE;
        else if (win_end) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cfg.cfg_ready = (state_reg == IDLE) || (state_reg == ARMED);
    busy          = (state_reg == RUN);
    done          = (state_reg == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pattern_reg <= '0;
      overlap_reg <= 1'b0;
      win_reg     <= '0;
      bitcnt_reg  <= '0;
      count_reg   <= '0;
      match_reg   <= 1'b0;
    end else begin
      if (cfg_fire) begin
        pattern_reg <= cfg.cfg_pattern;
        overlap_reg <= cfg.cfg_overlap;
        win_reg     <= cfg.cfg_win;
      end
      match_reg <= accept && hit;
      if (start_fire) begin
        bitcnt_reg <= '0;
        count_reg  <= '0;
      end else if (accept) begin
        bitcnt_reg <= bitcnt_post;
        if (hit && (count_reg != '1)) count_reg <= count_reg + CNT_W'(1);
      end
    end
  end

  assign match       = match_reg;
  assign match_count = count_reg;

`ifdef SEQ_DET_FIRST_IDX_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      first_idx <= '0;
      first_vld <= 1'b0;
    end else if (start_fire) begin
      first_idx <= '0;
      first_vld <= 1'b0;
    end else if (accept && hit && !first_vld) begin
      first_idx <= bitcnt_reg;
      first_vld <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Scoreboard bench for seq_detect_ctrl: stimulus queues expected match/done events, a monitor checks them.
module tb_seq_detect_ctrl;

  localparam int PAT_W   = 4;
  localparam int CNT_W   = 2;
  localparam int WIN_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic             m;
    logic             d;
    logic [CNT_W-1:0] c;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic in_valid = 1'b0;
  logic in_bit = 1'b0;
  logic busy;
  logic match;
  logic done;
  logic [CNT_W-1:0] match_count;

  ev_t exp_q[$];
  ev_t mon_e;
  int  checks  = 0;
  int  errors  = 0;
  int  exp_cnt = 0;

  always #5 clk = ~clk;

  seq_detect_ctrl_if #(.PAT_W(PAT_W), .WIN_W(WIN_W)) cif ();

`ifdef SEQ_DET_FIRST_IDX_EN
  logic [WIN_W-1:0] first_idx;
  logic             first_vld;
`endif

  seq_detect_ctrl #(
    .PAT_W (PAT_W),
    .CNT_W (CNT_W),
    .WIN_W (WIN_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg         (cif.slave),
    .start       (start),
    .stop        (stop),
    .in_valid    (in_valid),
    .in_bit      (in_bit),
    .busy        (busy),
    .match       (match),
    .match_count (match_count),
    .done        (done)
`ifdef SEQ_DET_FIRST_IDX_EN
    ,
    .first_idx   (first_idx),
    .first_vld   (first_vld)
`endif
  );

  // Monitor: every match or done presented by the DUT consumes one expected event.
  always @(negedge clk) begin
    if (rst && (match || done)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: actual match=%b done=%b count=%0d, required no event",
                 match, done, match_count);
      end else begin
        mon_e = exp_q.pop_front();
        if (match !== mon_e.m || done !== mon_e.d || match_count !== mon_e.c) begin
          errors++;
          $display("FAIL event: actual match=%b done=%b count=%0d, required match=%b done=%b count=%0d",
                   match, done, match_count, mon_e.m, mon_e.d, mon_e.c);
        end else begin
          $display("ok   event: match=%b done=%b count=%0d", match, done, match_count);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic configure(input logic [PAT_W-1:0] pat, input logic ov,
                           input logic [WIN_W-1:0] win, input logic with_start);
    cif.cfg_valid   = 1'b1;
    cif.cfg_pattern = pat;
    cif.cfg_overlap = ov;
    cif.cfg_win     = win;
    start           = with_start;
    if (with_start) exp_cnt = 0;
    tick();
    cif.cfg_valid = 1'b0;
    start         = 1'b0;
  endtask

  task automatic pulse_start();
    start   = 1'b1;
    exp_cnt = 0;
    tick();
    start = 1'b0;
  endtask

  // A valid 1 accompanies stop so a non-discarded bit would be visible.
  task automatic pulse_stop();
    stop     = 1'b1;
    in_valid = 1'b1;
    in_bit   = 1'b1;
    tick();
    stop     = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    in_valid = 1'b1;
    in_bit   = b;
    tick();
    in_valid = 1'b0;
  endtask

  // Bit masks are written oldest-first (MSB of the n-bit literal is bit 0 in time).
  task automatic run_stream(input int n, input logic [15:0] seq, input logic [15:0] mmask,
                            input logic [15:0] gmask, input int win);
    ev_t e;
    for (int i = 0; i < n; i++) begin
      if (gmask[n-1-i]) begin
        tick();
        tick();
      end
      e.m = mmask[n-1-i];
      e.d = (win != 0) && (i + 1 == win);
      if (e.m && exp_cnt < CNT_MAX) exp_cnt++;
      e.c = CNT_W'(exp_cnt);
      if (e.m || e.d) exp_q.push_back(e);
      send_bit(seq[n-1-i]);
    end
  endtask

  initial begin
    ev_t e;
    cif.cfg_valid   = 1'b0;
    cif.cfg_pattern = '0;
    cif.cfg_overlap = 1'b0;
    cif.cfg_win     = '0;

    #12;
    chk("rst_cfg_ready", 32'(cif.cfg_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_match", 32'(match), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_count", 32'(match_count), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    tick();

    // Overlapping detection of 1101 in 1101101
    configure(4'b1101, 1'b1, 8'd0, 1'b0);
    pulse_start();
    chk("ovl_busy", 32'(busy), 32'd1);
    chk("ovl_cfg_ready", 32'(cif.cfg_ready), 32'd0);
    run_stream(7, 16'b1101101, 16'b0001001, 16'b0, 0);
    tick();
    chk("ovl_count", 32'(match_count), 32'd2);
    pulse_stop();
    tick();
    chk("ovl_stop_busy", 32'(busy), 32'd0);
    chk("ovl_stop_count", 32'(match_count), 32'd2);

    // Non-overlapping detection on the same stream
    configure(4'b1101, 1'b0, 8'd0, 1'b0);
    pulse_start();
    run_stream(7, 16'b1101101, 16'b0001000, 16'b0, 0);
    tick();
    chk("novl_count", 32'(match_count), 32'd1);
    pulse_stop();

    // Bounded window of 8 bits with idle gaps
    configure(4'b1101, 1'b1, 8'd8, 1'b0);
    pulse_start();
    run_stream(7, 16'b1101011, 16'b0001000, 16'b0010010, 0);
    tick();
    chk("win_busy_before_last", 32'(busy), 32'd1);
    e.m = 1'b0;
    e.d = 1'b1;
    e.c = CNT_W'(1);
    exp_q.push_back(e);
    send_bit(1'b0);
    tick();
    chk("win_busy_after", 32'(busy), 32'd0);
    chk("win_idle_ready", 32'(cif.cfg_ready), 32'd1);
    chk("win_count_hold", 32'(match_count), 32'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("idle_start_ignored", 32'(busy), 32'd0);

    // Re-configure in ARMED together with start; hit on the final window bit
    configure(4'b0000, 1'b0, 8'd0, 1'b0);
    configure(4'b1101, 1'b1, 8'd4, 1'b1);
    chk("lastbit_busy", 32'(busy), 32'd1);
    run_stream(4, 16'b1101, 16'b0001, 16'b0, 4);
    tick();
    chk("lastbit_count", 32'(match_count), 32'd1);
    chk("lastbit_busy_after", 32'(busy), 32'd0);

    // Counter saturation at 2^CNT_W-1
    configure(4'b1111, 1'b1, 8'd0, 1'b0);
    pulse_start();
    run_stream(8, 16'b11111111, 16'b00011111, 16'b0, 0);
    tick();
    chk("sat_count", 32'(match_count), 32'd3);
    pulse_stop();

    // Abort after 5 bits; the bit offered with stop must not hit
    configure(4'b1111, 1'b1, 8'd0, 1'b0);
    pulse_start();
    run_stream(5, 16'b11111, 16'b00011, 16'b0, 0);
    pulse_stop();
    tick();
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_count", 32'(match_count), 32'd2);
    chk("abort_ready", 32'(cif.cfg_ready), 32'd1);

    // Asynchronous reset while a match pulse is pending
    configure(4'b1101, 1'b1, 8'd0, 1'b0);
    pulse_start();
    run_stream(3, 16'b110, 16'b0, 16'b0, 0);
    in_valid = 1'b1;
    in_bit   = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    #1 in_valid = 1'b0;
    chk("arst_match", 32'(match), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_count", 32'(match_count), 32'd0);
    chk("arst_ready", 32'(cif.cfg_ready), 32'd1);
    tick();
    rst = 1'b1;
    tick();
    tick();
    chk("post_rst_busy", 32'(busy), 32'd0);

    tick();
    tick();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
